// File: rtl/mem_seq_ctrl.sv
// Multi-cycle fetch/decode/data/commit sequencer sharing one
// single-port memory between instruction fetch and lw/sw access.
module mem_seq_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] wdata,
    output logic [31:0] instr,
    output logic [31:0] rdata_out,
    output logic        core_en,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        halted,
    output logic [1:0]  err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DATA,
        S_COMMIT,
        S_HALT
    } state_e;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        halted_q, halted_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] instret_q, instret_d;
    logic [15:0] wait_q, wait_d;
    logic [16:0] wait_inc;

    assign wait_inc = {1'b0, wait_q} + 17'd1;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        halted_d  = halted_q;
        err_d     = err_q;
        instret_d = instret_q;
        wait_d    = wait_q;
        m_req     = 1'b0;
        core_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FETCH: begin
                m_req  = 1'b1;
                addr_d = pc;
                we_d   = 1'b0;
                if (m_ready) begin
                    instr_d = m_rdata;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_inc[15:0];
                    if (wait_inc >= TO_LIM) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        err_d    = 2'b11;
                    end
                end
            end
            S_DECODE: begin
                if (mem_rd && mem_wr) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    err_d    = 2'b01;
                end else if ((mem_rd || mem_wr) && data_addr[1:0] != 2'b00) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    err_d    = 2'b10;
                end else if (mem_rd || mem_wr) begin
                    state_d = S_DATA;
                    wait_d  = '0;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_DATA: begin
                m_req   = 1'b1;
                addr_d  = data_addr;
                we_d    = mem_wr;
                wdata_d = wdata;
                if (m_ready) begin
                    if (!mem_wr) begin
                        rdata_d = m_rdata;
                    end
                    state_d = S_COMMIT;
                end else begin
                    wait_d = wait_inc[15:0];
                    if (wait_inc >= TO_LIM) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        err_d    = 2'b11;
                    end
                end
            end
            S_COMMIT: begin
                core_en   = 1'b1;
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
                wait_d    = '0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus fields are driven from next-state so the address follows
    // the live pc/data_addr while a request is open and holds afterwards.
    assign m_addr    = addr_d;
    assign m_we      = we_d;
    assign m_wdata   = wdata_d;
    assign instr     = instr_q;
    assign rdata_out = rdata_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign instret   = instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instr_q   <= NOP;
            rdata_q   <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            halted_q  <= 1'b0;
            err_q     <= 2'b00;
            instret_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
        end
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: small core/pc model plus a
// memory responder with programmable wait states.
module tb_mem_seq_ctrl;

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] LW   = 32'h0000_A103;
    localparam logic [31:0] SW   = 32'h0020_A223;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        mem_rd, mem_wr;
    logic [31:0] data_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] instr, rdata_out;
    logic        core_en, m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] instret;

    logic [31:0] pc_r;
    logic        force_rw = 1'b0;
    logic [31:0] mem [0:255];
    int          fetch_wait = 0;
    int          data_wait = 0;
    int          wcnt = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    logic        seen;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    mem_seq_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .data_addr (data_addr),
        .wdata     (wdata),
        .instr     (instr),
        .rdata_out (rdata_out),
        .core_en   (core_en),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .halted    (halted),
        .err       (err),
        .instret   (instret)
    );

    assign pc     = pc_r;
    assign mem_rd = force_rw | (instr[6:0] == 7'h03);
    assign mem_wr = force_rw | (instr[6:0] == 7'h23);

    always @(posedge clk) begin
        if (rst) pc_r <= '0;
        else if (core_en) pc_r <= pc_r + 32'd4;
    end

    always @(negedge clk) begin
        if (m_req) begin
            if (wcnt >= ((m_addr == pc_r) ? fetch_wait : data_wait)) begin
                m_ready = 1'b1;
                m_rdata = mem[m_addr[9:2]];
                wcnt    = 0;
                if (m_we) begin
                    last_wa = m_addr;
                    last_wd = m_wdata;
                end
            end else begin
                m_ready = 1'b0;
                m_rdata = '0;
                wcnt++;
            end
        end else begin
            m_ready = 1'b0;
            wcnt    = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        mem[0]  = ADDI;
        mem[1]  = LW;
        mem[2]  = SW;
        mem[3]  = LW;
        mem[64] = 32'hDEAD_BEEF;
        data_addr = 32'h100;
        data_wait = 2;

        // reset values
        tick();
        chk("rst_instr", instr, NOP);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_core_en", {31'd0, core_en}, 0);
        chk("rst_m_req", {31'd0, m_req}, 0);
        chk("rst_m_we", {31'd0, m_we}, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_err", {30'd0, err}, 0);
        chk("rst_instret", instret, 0);
        rst = 1'b0;

        // addi: FETCH, DECODE, COMMIT
        tick();
        chk("addi_fetch_req", {31'd0, m_req}, 1);
        chk("addi_fetch_addr", m_addr, 0);
        chk("addi_fetch_we", {31'd0, m_we}, 0);
        tick();
        chk("addi_dec_req", {31'd0, m_req}, 0);
        chk("addi_instr", instr, ADDI);
        tick();
        chk("addi_commit", {31'd0, core_en}, 1);
        tick();
        chk("addi_en_drop", {31'd0, core_en}, 0);
        chk("addi_instret", instret, 1);
        chk("lw_fetch_addr", m_addr, 4);

        // lw 0x100 with two data wait cycles
        tick();
        chk("lw_instr", instr, LW);
        tick();
        chk("lw_req", {31'd0, m_req}, 1);
        chk("lw_addr", m_addr, 32'h100);
        chk("lw_we", {31'd0, m_we}, 0);
        tick();
        tick();
        chk("lw_req_wait", {31'd0, m_req}, 1);
        chk("lw_noen_wait", {31'd0, core_en}, 0);
        tick();
        chk("lw_commit", {31'd0, core_en}, 1);
        chk("lw_rdata", rdata_out, 32'hDEAD_BEEF);
        data_addr = 32'h104;
        wdata     = 32'h55AA_55AA;

        // sw 0x104 with two data wait cycles
        tick();
        chk("sw_instret_prev", instret, 2);
        tick();
        chk("sw_instr", instr, SW);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_req", {31'd0, m_req}, 1);
            chk("sw_we", {31'd0, m_we}, 1);
            chk("sw_addr", m_addr, 32'h104);
            chk("sw_wdata", m_wdata, 32'h55AA_55AA);
        end
        tick();
        chk("sw_commit", {31'd0, core_en}, 1);
        chk("sw_rdata_held", rdata_out, 32'hDEAD_BEEF);
        chk("sw_mem_addr", last_wa, 32'h104);
        chk("sw_mem_data", last_wd, 32'h55AA_55AA);
        data_addr = 32'h102;

        // misaligned lw halts from DECODE
        tick();
        tick();
        tick();
        chk("mis_halted", {31'd0, halted}, 1);
        chk("mis_err", {30'd0, err}, 2'b10);
        chk("mis_req", {31'd0, m_req}, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (core_en || m_req) seen = 1'b1;
        end
        chk("mis_quiet", {31'd0, seen}, 0);
        chk("mis_instret", instret, 3);
        chk("mis_sticky", {31'd0, halted}, 1);

        // fetch timeout after four wait cycles
        fetch_wait = 99;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("to_req_4th", {31'd0, m_req}, 1);
        chk("to_not_yet", {31'd0, halted}, 0);
        tick();
        chk("to_halted", {31'd0, halted}, 1);
        chk("to_err", {30'd0, err}, 2'b11);
        chk("to_req_drop", {31'd0, m_req}, 0);

        // ready on the last allowed cycle completes normally
        fetch_wait = 3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("edge_halted", {31'd0, halted}, 0);
        chk("edge_instr", instr, ADDI);
        tick();
        chk("edge_commit", {31'd0, core_en}, 1);
        chk("edge_err", {30'd0, err}, 0);

        // lw and sw both asserted
        fetch_wait = 0;
        force_rw   = 1'b1;
        data_addr  = 32'h100;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("both_halted", {31'd0, halted}, 1);
        chk("both_err", {30'd0, err}, 2'b01);
        force_rw = 1'b0;

        // reset in the middle of a sw data access
        mem[0]    = SW;
        data_addr = 32'h104;
        wdata     = 32'h1234_5678;
        data_wait = 10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("rstd_req", {31'd0, m_req}, 1);
        chk("rstd_we", {31'd0, m_we}, 1);
        rst = 1'b1;
        tick();
        chk("rstd_req_drop", {31'd0, m_req}, 0);
        chk("rstd_instr", instr, NOP);
        chk("rstd_we_drop", {31'd0, m_we}, 0);
        rst = 1'b0;

        // instret wraps on commit
        mem[0] = ADDI;
        tick();
        force dut.instret_q = 32'hFFFF_FFFF;
        tick();
        release dut.instret_q;
        tick();
        chk("wrap_commit", {31'd0, core_en}, 1);
        chk("wrap_pre", instret, 32'hFFFF_FFFF);
        tick();
        chk("wrap_post", instret, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
